// File: rtl/uart_rx.sv
// UART receiver: START, 8 data bits LSB-first, PARITY, STOP_SIZE stop bits, oversampled on baud_clk.
// Define UART_RX_MAJORITY_EN to take each bit as the 2-of-3 majority around its centre.
module uart_rx #(
  parameter int OVERSAMPLE = 8,
  parameter int PARITY     = 0,
  parameter int STOP_SIZE  = 1
) (
  input  logic       baud_clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_rx,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic STOP_LAST = (STOP_SIZE == 2);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [TW-1:0] TICK_RESUME = TW'(1);
`else
  localparam logic [TW-1:0] TICK_RESUME = TW'(0);
`endif

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

  state_t        state;
  logic          rx_meta, rx_s, rx_s_d;
  logic [TW-1:0] tick;
  logic [2:0]    bit_idx;
  logic          stop_idx, stop_done, ferr, par_bit;
  logic [7:0]    shift;
  logic          fall_edge, mid_hit, sample_now, sample_bit, exp_par;

  always_comb begin
    fall_edge = ~rx_s & rx_s_d;
    mid_hit   = 1'b0;
    case (state)
      S_START:          mid_hit = (tick == TICK_HALF);
      S_DATA, S_PARITY: mid_hit = (tick == TICK_LAST);
      S_STOP:           mid_hit = (tick == TICK_LAST) && !stop_done;
      default:          mid_hit = 1'b0;
    endcase
    exp_par = (PARITY == 0) ? ^shift : ~^shift;
  end

`ifdef UART_RX_MAJORITY_EN
  // The decision lands one tick after the centre so the sample after it can vote too.
  logic rx_s_d2, pend;

  always_ff @(posedge baud_clk) begin
    if (reset) begin
      rx_s_d2 <= 1'b1;
      pend    <= 1'b0;
    end else begin
      rx_s_d2 <= rx_s_d;
      pend    <= mid_hit;
    end
  end

  assign sample_now = pend;
  assign sample_bit = (rx_s & rx_s_d) | (rx_s & rx_s_d2) | (rx_s_d & rx_s_d2);
`else
  assign sample_now = mid_hit;
  assign sample_bit = rx_s;
`endif

  always_ff @(posedge baud_clk) begin
    if (reset) begin
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      rx_s_d     <= 1'b1;
      state      <= S_IDLE;
      tick       <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      stop_done  <= 1'b0;
      ferr       <= 1'b0;
      par_bit    <= 1'b0;
      shift      <= '0;
      data_rx    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      rx_busy    <= 1'b0;
    end else begin
      rx_meta  <= rx;
      rx_s     <= rx_meta;
      rx_s_d   <= rx_s;
      rx_valid <= 1'b0;
      if (state == S_IDLE || state == S_BREAK)
        tick <= '0;
      else
        tick <= (tick == TICK_LAST) ? '0 : tick + 1'b1;

      case (state)
        S_IDLE: begin
          if (fall_edge) begin
            state   <= S_START;
            tick    <= '0;
            rx_busy <= 1'b1;
          end
        end
        // Re-centre the tick counter on the start bit so later samples fall mid-bit.
        S_START: begin
          if (sample_now) begin
            if (!sample_bit) begin
              state   <= S_DATA;
              tick    <= TICK_RESUME;
              bit_idx <= '0;
            end else begin
              state   <= S_IDLE;
              rx_busy <= 1'b0;
            end
          end
        end
        S_DATA: begin
          if (sample_now) begin
            shift <= {sample_bit, shift[7:1]};
            if (bit_idx == 3'd7)
              state <= S_PARITY;
            else
              bit_idx <= bit_idx + 3'd1;
          end
        end
        S_PARITY: begin
          if (sample_now) begin
            par_bit   <= sample_bit;
            state     <= S_STOP;
            stop_idx  <= 1'b0;
            stop_done <= 1'b0;
            ferr      <= 1'b0;
          end
        end
        // Leave at mid stop bit so a start edge right after the frame is still caught.
        S_STOP: begin
          if (stop_done) begin
            data_rx    <= shift;
            parity_err <= (par_bit != exp_par);
            frame_err  <= ferr;
            rx_valid   <= 1'b1;
            stop_done  <= 1'b0;
            if (ferr) begin
              state <= S_BREAK;
            end else begin
              state   <= S_IDLE;
              rx_busy <= 1'b0;
            end
          end else if (sample_now) begin
            if (!sample_bit)
              ferr <= 1'b1;
            if (stop_idx == STOP_LAST)
              stop_done <= 1'b1;
            else
              stop_idx <= 1'b1;
          end
        end
        S_BREAK: begin
          if (rx_s) begin
            state   <= S_IDLE;
            rx_busy <= 1'b0;
          end
        end
        default: begin
          state   <= S_IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
